// File: rtl/psk_pkg.sv
// ============================================================================
// Module : psk_pkg
// Brief  : Shared state encoding and mode constants for the PSK mode sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package psk_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_ACQ    = 2'd0;
    localparam state_t ST_LOCKED = 2'd1;
    localparam state_t ST_DRAIN  = 2'd2;
    localparam state_t ST_SWITCH = 2'd3;

    localparam logic MODE_BPSK = 1'b1;
    localparam logic MODE_QPSK = 1'b0;

endpackage

`default_nettype wire

// File: rtl/psk_lock_detect.sv
// ============================================================================
// Module : psk_lock_detect
// Brief  : Saturating |error| compare and consecutive in-lock sample counter.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module psk_lock_detect #(
    parameter int WIDTH       = 16,
    parameter int LOCK_THRESH = 2048,
    parameter int LOCK_COUNT  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_err_data,
    input  logic             i_err_valid,
    output logic             o_lock_hit,
    output logic             o_loss_hit
);

    localparam int                 c_cnt_w    = $clog2(LOCK_COUNT + 1);
    localparam logic [c_cnt_w-1:0] c_lock_cnt = c_cnt_w'(LOCK_COUNT);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [WIDTH:0]     c_lock_thr = (WIDTH + 1)'(LOCK_THRESH);
    localparam logic [WIDTH:0]     c_loss_thr = (WIDTH + 1)'(2 * LOCK_THRESH);
    localparam logic [WIDTH-1:0]   c_most_neg = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]   c_most_pos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0]   c_one      = WIDTH'(1);

    logic [WIDTH-1:0]   w_abs;
    logic [WIDTH:0]     w_abs_ext;
    logic               w_good;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;

    // The most negative code has no positive twin, so it saturates.
    always_comb begin
        w_abs = i_err_data;
        if (i_err_data == c_most_neg) begin
            w_abs = c_most_pos;
        end else if (i_err_data[WIDTH-1]) begin
            w_abs = ~i_err_data + c_one;
        end
    end

    assign w_abs_ext  = {1'b0, w_abs};
    assign w_good     = (w_abs_ext <= c_lock_thr);
    assign o_loss_hit = i_err_valid && (w_abs_ext > c_loss_thr);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clear) begin
            w_cnt_nxt = '0;
        end else if (i_enable && i_err_valid) begin
            if (!w_good) begin
                w_cnt_nxt = '0;
            end else if (r_cnt != c_lock_cnt) begin
                w_cnt_nxt = r_cnt + c_cnt_one;
            end
        end
    end

    assign o_lock_hit = i_enable && !i_clear && (w_cnt_nxt == c_lock_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/psk_mode_sequencer.sv
// ============================================================================
// Module : psk_mode_sequencer
// Brief  : BPSK/QPSK mode-change sequencer with drain, loop clear and lock
//          detection. Optional acquisition timeout: PSK_SEQ_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module psk_mode_sequencer
    import psk_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int DRAIN_CYCLES   = 4,
    parameter int LOCK_THRESH    = 2048,
    parameter int LOCK_COUNT     = 64,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_req_tdata,
    input  logic             mode_req_tvalid,
    output logic             mode_req_tready,
    input  logic [WIDTH-1:0] error_tdata,
    input  logic             error_tvalid,
    output logic             is_bpsk,
    output logic             loop_hold,
    output logic             loop_clr,
    output logic             locked,
    output logic             lock_fail,
    output logic             busy
);

    localparam int                   c_drain_w    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(DRAIN_CYCLES - 1);
    localparam logic [c_drain_w-1:0] c_drain_one  = c_drain_w'(1);

    if (DRAIN_CYCLES < 1 || LOCK_COUNT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("psk_mode_sequencer: DRAIN_CYCLES, LOCK_COUNT and TIMEOUT_CYCLES must be >= 1");
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_accept;
    logic                 w_start;
    logic                 w_lock_hit;
    logic                 w_loss_hit;
    logic                 w_drain_done;
    logic [c_drain_w-1:0] r_drain_cnt;
    logic                 r_req;

    logic w_hold_nxt, w_clr_nxt, w_locked_nxt, w_bpsk_nxt;
    logic r_is_bpsk, r_loop_hold, r_loop_clr, r_locked, r_busy;

    assign mode_req_tready = (r_state == ST_ACQ) || (r_state == ST_LOCKED);
    assign w_accept        = mode_req_tvalid && mode_req_tready;
    // A same-mode request while locked is a no-op; in ACQ every request restarts.
    assign w_start         = w_accept && ((r_state == ST_ACQ) || (mode_req_tdata != r_is_bpsk));
    assign w_drain_done    = (r_drain_cnt == c_drain_last);

    psk_lock_detect #(
        .WIDTH       (WIDTH),
        .LOCK_THRESH (LOCK_THRESH),
        .LOCK_COUNT  (LOCK_COUNT)
    ) u_lock_detect (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (r_state != ST_ACQ),
        .i_enable    (r_state == ST_ACQ),
        .i_err_data  (error_tdata),
        .i_err_valid (error_tvalid),
        .o_lock_hit  (w_lock_hit),
        .o_loss_hit  (w_loss_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACQ: begin
                if (w_start) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_lock_hit) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_start) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_loss_hit) begin
                    w_state_nxt = ST_ACQ;
                end
            end
            ST_DRAIN: begin
                if (w_drain_done) begin
                    w_state_nxt = ST_SWITCH;
                end
            end
            default: begin
                w_state_nxt = ST_ACQ;
            end
        endcase
    end

    // Outputs are registered versions of the next-state decode.
    always_comb begin
        w_hold_nxt   = (w_state_nxt == ST_DRAIN) || (w_state_nxt == ST_SWITCH);
        w_clr_nxt    = (w_state_nxt == ST_SWITCH);
        w_locked_nxt = (w_state_nxt == ST_LOCKED);
        w_bpsk_nxt   = (w_state_nxt == ST_SWITCH) ? r_req : r_is_bpsk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_bpsk   <= MODE_BPSK;
            r_loop_hold <= 1'b0;
            r_loop_clr  <= 1'b0;
            r_locked    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_is_bpsk   <= w_bpsk_nxt;
            r_loop_hold <= w_hold_nxt;
            r_loop_clr  <= w_clr_nxt;
            r_locked    <= w_locked_nxt;
            r_busy      <= w_hold_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req       <= MODE_QPSK;
            r_drain_cnt <= '0;
        end else begin
            if (w_start) begin
                r_req <= mode_req_tdata;
            end
            if (r_state == ST_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + c_drain_one;
            end else begin
                r_drain_cnt <= '0;
            end
        end
    end

`ifdef PSK_SEQ_TIMEOUT_EN
    localparam int                et_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [et_w-1:0]   c_to_max  = et_w'(TIMEOUT_CYCLES);
    localparam logic [et_w-1:0]   c_to_last = et_w'(TIMEOUT_CYCLES - 1);
    localparam logic [et_w-1:0]   c_to_one  = et_w'(1);

    logic [et_w-1:0] r_to_cnt;
    logic            r_lock_fail;

    // Counts ACQ cycles since the last mode switch; saturates, flag is sticky.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt    <= '0;
            r_lock_fail <= 1'b0;
        end else if (w_state_nxt == ST_SWITCH) begin
            r_to_cnt    <= '0;
            r_lock_fail <= 1'b0;
        end else if ((r_state == ST_ACQ) && (r_to_cnt != c_to_max)) begin
            r_to_cnt <= r_to_cnt + c_to_one;
            if (r_to_cnt == c_to_last) begin
                r_lock_fail <= 1'b1;
            end
        end
    end

    assign lock_fail = r_lock_fail;
`else
    assign lock_fail = 1'b0;
`endif

    assign is_bpsk   = r_is_bpsk;
    assign loop_hold = r_loop_hold;
    assign loop_clr  = r_loop_clr;
    assign locked    = r_locked;
    assign busy      = r_busy;

endmodule

`default_nettype wire
